// File: rtl/i2c_dac_pkg.sv
// Shared definitions for the octal-DAC I2C target and the DAC-load master:
// FSM states, command-byte layout and DAC code width.
package i2c_dac_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_A,
        ST_CMD,
        ST_ACK_C,
        ST_DHI,
        ST_ACK_H,
        ST_DLO,
        ST_ACK_L,
        ST_HOLD
    } tgt_state_t;

    localparam logic [6:0] DEF_DEV_ADDR = 7'h2A;
    localparam int         DAC_W        = 12;
    localparam logic [4:0] CMD_PREFIX   = 5'b00001;
    localparam int         CMD_PFX_MSB  = 7;
    localparam int         CMD_PFX_LSB  = 3;
    localparam int         CMD_CH_MSB   = 2;
    localparam int         CMD_CH_LSB   = 0;

    function automatic logic is_data_state(input tgt_state_t s);
        return (s == ST_ADDR) || (s == ST_CMD) || (s == ST_DHI) || (s == ST_DLO);
    endfunction

    function automatic logic is_ack_state(input tgt_state_t s);
        return (s == ST_ACK_A) || (s == ST_ACK_C) || (s == ST_ACK_H) || (s == ST_ACK_L);
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: synchroniser, optional glitch filter (I2C_TGT_GLITCH_FILT_EN),
// SCL edge strobes and START/STOP strobes. Both lines idle high out of reset.
module i2c_line_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda,
    output logic start,
    output logic stop
);

    // Bit 0 carries SCL, bit 1 carries SDA through every stage.
    logic [1:0] r_sync [SYNC_STAGES];
    logic [1:0] w_line;
    logic [1:0] w_clean;
    logic [1:0] r_prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 2'b11;
        end else begin
            r_sync[0] <= {sda_i, scl_i};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_line = r_sync[SYNC_STAGES-1];

`ifdef I2C_TGT_GLITCH_FILT_EN
    localparam int CW = $clog2(FILT_LEN) + 1;
    logic [1:0]    r_filt;
    logic [CW-1:0] r_cnt [2];

    // A line only follows its input after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_filt <= 2'b11;
            for (int l = 0; l < 2; l++) r_cnt[l] <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (w_line[l] == r_filt[l]) begin
                    r_cnt[l] <= '0;
                end else if (r_cnt[l] == CW'(FILT_LEN - 1)) begin
                    r_filt[l] <= w_line[l];
                    r_cnt[l]  <= '0;
                end else begin
                    r_cnt[l] <= r_cnt[l] + 1'b1;
                end
            end
        end
    end

    assign w_clean = r_filt;
`else
    assign w_clean = w_line;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_prev <= 2'b11;
        else         r_prev <= w_clean;
    end

    assign scl_rise = w_clean[0] & ~r_prev[0];
    assign scl_fall = ~w_clean[0] & r_prev[0];
    assign sda      = w_clean[1];
    assign start    = ~w_clean[1] & r_prev[1] & w_clean[0] & r_prev[0];
    assign stop     = w_clean[1] & ~r_prev[1] & w_clean[0] & r_prev[0];

endmodule

// File: rtl/i2c_dac_target.sv
// Write-only I2C target modelling an octal 12-bit DAC with LDAC transfer.
// Optional SCL/SDA glitch filter enabled by defining I2C_TGT_GLITCH_FILT_EN.
module i2c_dac_target
    import i2c_dac_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEF_DEV_ADDR,
    parameter int         NUM_CH      = 8,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_oe,
    input  logic                      ldac_n,
    output logic [NUM_CH*DAC_W-1:0]   dac_out,
    output logic                      wr_strobe,
    output logic [2:0]                wr_ch,
    output logic                      busy,
    output logic                      frame_err
);

    logic w_scl_rise, w_scl_fall, w_sda, w_start, w_stop;

    i2c_line_cond #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_line_cond (
        .clk      (clk),
        .resetn   (resetn),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (w_scl_rise),
        .scl_fall (w_scl_fall),
        .sda      (w_sda),
        .start    (w_start),
        .stop     (w_stop)
    );

    tgt_state_t r_state, w_state_nxt;
    logic [3:0]             r_bitcnt;
    logic [7:0]             r_shift;
    logic                   r_ack_ok;
    logic [2:0]             r_ch;
    logic [3:0]             r_hi;
    logic [DAC_W-1:0]       r_in [NUM_CH];
    logic [NUM_CH*DAC_W-1:0] r_dac;
    logic [SYNC_STAGES-1:0] r_ldac_sync;
    logic                   r_sda_oe;
    logic                   r_wr_strobe;
    logic [2:0]             r_wr_ch;
    logic                   r_busy;
    logic                   r_ferr;

    logic       w_bus_evt;
    logic       w_rise;
    logic       w_fall;
    logic [7:0] w_byte;
    logic       w_byte_last;
    logic       w_byte_ok;
    logic       w_byte_end;

    // START/STOP take priority over any SCL edge seen in the same cycle.
    assign w_bus_evt   = w_start | w_stop;
    assign w_rise      = w_scl_rise & ~w_bus_evt;
    assign w_fall      = w_scl_fall & ~w_bus_evt;
    assign w_byte      = {r_shift[6:0], w_sda};
    assign w_byte_last = w_rise && is_data_state(r_state) && (r_bitcnt == 4'd7);
    assign w_byte_end  = w_fall && is_data_state(r_state) && (r_bitcnt == 4'd8);

    always_comb begin
        w_byte_ok = 1'b0;
        case (r_state)
            ST_ADDR: w_byte_ok = (w_byte == {DEV_ADDR, 1'b0});
            ST_CMD:  w_byte_ok = (w_byte[CMD_PFX_MSB:CMD_PFX_LSB] == CMD_PREFIX) &&
                                 ({29'd0, w_byte[CMD_CH_MSB:CMD_CH_LSB]} < 32'(NUM_CH));
            ST_DHI:  w_byte_ok = (w_byte[7:4] == 4'd0);
            ST_DLO:  w_byte_ok = 1'b1;
            default: w_byte_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = ST_ADDR;
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_ADDR:  if (w_byte_end) w_state_nxt = r_ack_ok ? ST_ACK_A : ST_HOLD;
                ST_CMD:   if (w_byte_end) w_state_nxt = r_ack_ok ? ST_ACK_C : ST_HOLD;
                ST_DHI:   if (w_byte_end) w_state_nxt = r_ack_ok ? ST_ACK_H : ST_HOLD;
                ST_DLO:   if (w_byte_end) w_state_nxt = r_ack_ok ? ST_ACK_L : ST_HOLD;
                ST_ACK_A: if (w_fall) w_state_nxt = ST_CMD;
                ST_ACK_C: if (w_fall) w_state_nxt = ST_DHI;
                ST_ACK_H: if (w_fall) w_state_nxt = ST_DLO;
                ST_ACK_L: if (w_fall) w_state_nxt = ST_HOLD;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // SDA is pulled low exactly while the FSM sits in an ACK slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_sda_oe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sda_oe <= is_ack_state(w_state_nxt);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_ack_ok    <= 1'b0;
            r_ch        <= '0;
            r_hi        <= '0;
            r_wr_strobe <= 1'b0;
            r_wr_ch     <= '0;
            r_busy      <= 1'b0;
            r_ferr      <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) r_in[k] <= '0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_bus_evt) begin
                r_bitcnt <= '0;
                r_busy   <= w_start;
                if (w_start) r_ferr <= 1'b0;
            end else if (w_rise && is_data_state(r_state) && (r_bitcnt < 4'd8)) begin
                r_bitcnt <= r_bitcnt + 1'b1;
                r_shift  <= w_byte;
            end else if (w_byte_end) begin
                r_bitcnt <= '0;
            end

            if (w_byte_last) begin
                r_ack_ok <= w_byte_ok;
                if (!w_byte_ok && (r_state == ST_CMD || r_state == ST_DHI)) r_ferr <= 1'b1;
                if (w_byte_ok && r_state == ST_CMD) r_ch <= w_byte[CMD_CH_MSB:CMD_CH_LSB];
                if (w_byte_ok && r_state == ST_DHI) r_hi <= w_byte[3:0];
                if (r_state == ST_DLO) begin
                    r_in[r_ch]  <= {r_hi, w_byte};
                    r_wr_strobe <= 1'b1;
                    r_wr_ch     <= r_ch;
                end
            end
        end
    end

    // LDAC low makes the output registers transparent to the input registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ldac_sync <= '1;
            r_dac       <= '0;
        end else begin
            r_ldac_sync <= {r_ldac_sync[SYNC_STAGES-2:0], ldac_n};
            if (!r_ldac_sync[SYNC_STAGES-1]) begin
                for (int k = 0; k < NUM_CH; k++) r_dac[k*DAC_W +: DAC_W] <= r_in[k];
            end
        end
    end

    assign sda_oe    = r_sda_oe;
    assign dac_out   = r_dac;
    assign wr_strobe = r_wr_strobe;
    assign wr_ch     = r_wr_ch;
    assign busy      = r_busy;
    assign frame_err = r_ferr;

endmodule
